// File: rtl/ucode_loader.sv
// Boot-time loader for the writable control store: assembles microinstruction words
// from a byte stream, writes them sequentially, then releases the microsequencer.
module ucode_loader #(
  parameter int ADDR_WIDTH = 13,
  parameter int WORD_WIDTH = 48,
  parameter int BYTE_COUNT = 6,
  parameter int WORD_COUNT = 8192
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  store_write,
  output logic [ADDR_WIDTH-1:0] store_addr,
  output logic [WORD_WIDTH-1:0] store_data,
  output logic                  seq_notReset,
  output logic                  done,
  output logic [7:0]            checksum
);

  localparam int CNT_W = (BYTE_COUNT > 1) ? $clog2(BYTE_COUNT) : 1;
  localparam int WIDE  = BYTE_COUNT * 8;
  localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(BYTE_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_COUNT - 1);

  typedef enum logic [1:0] {LOAD, WRITE, RUN} state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      byte_cnt;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [WORD_WIDTH-1:0] asm_reg, asm_next, byte_mask, byte_ins;
  logic [7:0]            sum_reg;
  logic [CNT_W+2:0]      shamt;
  logic                  accept;

  assign accept = in_valid && in_ready;

  // Little-endian byte insertion; the cast to WORD_WIDTH drops bits above the word.
  assign shamt     = {byte_cnt, 3'b000};
  assign byte_mask = WORD_WIDTH'(WIDE'(8'hFF) << shamt);
  assign byte_ins  = WORD_WIDTH'(WIDE'(in_data) << shamt);
  assign asm_next  = (asm_reg & ~byte_mask) | byte_ins;

  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    store_write  = 1'b0;
    seq_notReset = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && byte_cnt == LAST_BYTE)
          state_next = WRITE;
      end
      WRITE: begin
        store_write = 1'b1;
        state_next  = (word_addr == LAST_ADDR) ? RUN : LOAD;
      end
      RUN: begin
        seq_notReset = 1'b1;
        if (reload)
          state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= LOAD;
      byte_cnt  <= '0;
      word_addr <= '0;
      asm_reg   <= '0;
      sum_reg   <= '0;
    end else begin
      state <= state_next;
      case (state)
        LOAD: begin
          if (accept) begin
            asm_reg  <= asm_next;
            sum_reg  <= sum_reg + in_data;
            byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + CNT_W'(1);
          end
        end
        WRITE: begin
          if (word_addr != LAST_ADDR)
            word_addr <= word_addr + ADDR_WIDTH'(1);
        end
        RUN: begin
          // A reload restarts the whole load from address zero.
          if (reload) begin
            byte_cnt  <= '0;
            word_addr <= '0;
            asm_reg   <= '0;
            sum_reg   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign store_addr = word_addr;
  assign store_data = asm_reg;
  assign checksum   = sum_reg;
  assign done       = seq_notReset;

endmodule

// File: tb/tb_ucode_loader.sv
// Bench for ucode_loader: a 48-bit and a 47-bit instance share one randomized byte stream
// and are checked against word/checksum expectations rebuilt from the bytes sent.
module tb_ucode_loader;

  typedef logic [7:0] byte_q_t [$];

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        reload = 1'b0;

  logic        in_ready_a, store_write_a, seq_notReset_a, done_a;
  logic [12:0] store_addr_a;
  logic [47:0] store_data_a;
  logic [7:0]  checksum_a;

  logic        in_ready_b, store_write_b, seq_notReset_b, done_b;
  logic [0:0]  store_addr_b;
  logic [46:0] store_data_b;
  logic [7:0]  checksum_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  ucode_loader #(.ADDR_WIDTH(13), .WORD_WIDTH(48), .BYTE_COUNT(6), .WORD_COUNT(2)) dut_a (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .reload(reload), .store_write(store_write_a),
    .store_addr(store_addr_a), .store_data(store_data_a),
    .seq_notReset(seq_notReset_a), .done(done_a), .checksum(checksum_a)
  );

  ucode_loader #(.ADDR_WIDTH(1), .WORD_WIDTH(47), .BYTE_COUNT(6), .WORD_COUNT(2)) dut_b (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .reload(reload), .store_write(store_write_b),
    .store_addr(store_addr_b), .store_data(store_data_b),
    .seq_notReset(seq_notReset_b), .done(done_b), .checksum(checksum_b)
  );

  // Word w is bytes 6w..6w+5, first byte in the least significant position.
  function automatic logic [47:0] build_word(input byte_q_t b, input int w);
    logic [47:0] r;
    r = '0;
    for (int k = 0; k < 6; k++)
      r = r | (48'(b[6*w+k]) << (8*k));
    return r;
  endfunction

  function automatic logic [7:0] sum_bytes(input byte_q_t b);
    int s;
    s = 0;
    foreach (b[i]) s += int'(b[i]);
    return 8'(s % 256);
  endfunction

  task automatic apply_reset();
    reset = 1'b1; in_valid = 1'b0; reload = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    tests_run++;
    if (in_ready_a !== 1'b1 || store_write_a !== 1'b0 || store_addr_a !== 13'd0 ||
        store_data_a !== 48'd0 || seq_notReset_a !== 1'b0 || done_a !== 1'b0 || checksum_a !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL %s_a: got rdy=%0b we=%0b addr=%0h data=%h nrst=%0b done=%0b sum=%h want 1 0 0 0 0 0 00",
               tag, in_ready_a, store_write_a, store_addr_a, store_data_a, seq_notReset_a, done_a, checksum_a);
    end
    tests_run++;
    if (in_ready_b !== 1'b1 || store_write_b !== 1'b0 || store_addr_b !== 1'b0 ||
        store_data_b !== 47'd0 || seq_notReset_b !== 1'b0 || done_b !== 1'b0 || checksum_b !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL %s_b: got rdy=%0b we=%0b addr=%0h data=%h nrst=%0b done=%0b sum=%h want 1 0 0 0 0 0 00",
               tag, in_ready_b, store_write_b, store_addr_b, store_data_b, seq_notReset_b, done_b, checksum_b);
    end
  endtask

  // mode 0: valid held high, 1: valid toggles every cycle, 2: random valid.
  // rl=1 pulses reload randomly while the load is in progress.
  task automatic stream(input byte_q_t bytes, input int mode, input bit rl);
    int idx, guard, w;
    bit expect_write;
    logic [47:0] word;
    idx = 0; guard = 0; expect_write = 0;
    while ((idx < bytes.size() || expect_write) && guard < 1000) begin
      @(negedge clock);
      guard++;
      reload = rl ? 1'($urandom_range(0, 1)) : 1'b0;
      if (expect_write) begin
        w = idx / 6 - 1;
        word = build_word(bytes, w);
        tests_run++;
        if (store_write_a !== 1'b1 || store_addr_a !== 13'(w) || store_data_a !== word) begin
          tests_failed++;
          $display("[TB] FAIL write_a w%0d: got we=%0b addr=%0h data=%h want we=1 addr=%0h data=%h",
                   w, store_write_a, store_addr_a, store_data_a, w, word);
        end
        tests_run++;
        if (store_write_b !== 1'b1 || store_addr_b !== 1'(w) || store_data_b !== word[46:0]) begin
          tests_failed++;
          $display("[TB] FAIL write_b w%0d: got we=%0b addr=%0h data=%h want we=1 addr=%0h data=%h",
                   w, store_write_b, store_addr_b, store_data_b, 1'(w), word[46:0]);
        end
        in_valid = 1'b1;
        in_data  = (idx < bytes.size()) ? bytes[idx] : 8'($urandom);
        tests_run++;
        if (in_ready_a !== 1'b0 || in_ready_b !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL ready_in_write w%0d: got %0b/%0b want 0/0", w, in_ready_a, in_ready_b);
        end
        expect_write = 0;
      end else begin
        tests_run++;
        if (store_write_a !== 1'b0 || store_write_b !== 1'b0 || done_a !== 1'b0 || done_b !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL idle_outputs byte%0d: got we=%0b/%0b done=%0b/%0b want 0/0 0/0",
                   idx, store_write_a, store_write_b, done_a, done_b);
        end
        case (mode)
          0: in_valid = 1'b1;
          1: in_valid = (guard % 2 == 1);
          default: in_valid = 1'($urandom_range(0, 1));
        endcase
        in_data = bytes[idx];
        if (in_valid && in_ready_a) begin
          idx++;
          if (idx % 6 == 0) expect_write = 1;
        end
      end
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    reload   = 1'b0;
    tests_run++;
    if (idx != bytes.size() || expect_write) begin
      tests_failed++;
      $display("[TB] FAIL stream_timeout: got %0d bytes accepted want %0d", idx, bytes.size());
    end
  endtask

  task automatic check_loaded(input string tag, input logic [7:0] exp_sum);
    @(negedge clock);
    tests_run++;
    if (done_a !== 1'b1 || seq_notReset_a !== 1'b1 || in_ready_a !== 1'b0 || checksum_a !== exp_sum) begin
      tests_failed++;
      $display("[TB] FAIL %s_a: got done=%0b nrst=%0b rdy=%0b sum=%h want 1 1 0 %h",
               tag, done_a, seq_notReset_a, in_ready_a, checksum_a, exp_sum);
    end
    tests_run++;
    if (done_b !== 1'b1 || seq_notReset_b !== 1'b1 || in_ready_b !== 1'b0 || checksum_b !== exp_sum) begin
      tests_failed++;
      $display("[TB] FAIL %s_b: got done=%0b nrst=%0b rdy=%0b sum=%h want 1 1 0 %h",
               tag, done_b, seq_notReset_b, in_ready_b, checksum_b, exp_sum);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_reset_values("reset_state");
  endtask

  task automatic test_sequential();
    byte_q_t q;
    for (int i = 1; i <= 12; i++) q.push_back(8'(i));
    stream(q, 0, 1'b0);
    check_loaded("seq_done", 8'h4E);
  endtask

  task automatic test_run_ignores_bytes();
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      tests_run++;
      if (store_write_a !== 1'b0 || in_ready_a !== 1'b0 || done_a !== 1'b1 || checksum_a !== 8'h4E) begin
        tests_failed++;
        $display("[TB] FAIL run_ignore c%0d: got we=%0b rdy=%0b done=%0b sum=%h want 0 0 1 4e",
                 i, store_write_a, in_ready_a, done_a, checksum_a);
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic test_reload();
    byte_q_t q;
    @(negedge clock);
    reload = 1'b1;
    @(negedge clock);
    reload = 1'b0;
    tests_run++;
    if (seq_notReset_a !== 1'b0 || in_ready_a !== 1'b1 || checksum_a !== 8'h00 ||
        done_a !== 1'b0 || store_addr_a !== 13'd0 || seq_notReset_b !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reload_restart: got nrst=%0b rdy=%0b sum=%h done=%0b addr=%0h nrst_b=%0b want 0 1 00 0 0 0",
               seq_notReset_a, in_ready_a, checksum_a, done_a, store_addr_a, seq_notReset_b);
    end
    for (int i = 0; i < 12; i++) q.push_back(8'hFF);
    stream(q, 0, 1'b0);
    check_loaded("reload_done", 8'hF4);
    tests_run++;
    if (store_data_a !== 48'hFFFF_FFFF_FFFF || store_data_b !== 47'h7FFF_FFFF_FFFF) begin
      tests_failed++;
      $display("[TB] FAIL top_bit_trim: got %h/%h want ffffffffffff/7fffffffffff", store_data_a, store_data_b);
    end
  endtask

  task automatic test_gappy();
    byte_q_t q;
    apply_reset();
    for (int i = 1; i <= 12; i++) q.push_back(8'(i));
    stream(q, 1, 1'b0);
    check_loaded("gappy_done", 8'h4E);
  endtask

  task automatic test_reload_ignored();
    byte_q_t q;
    apply_reset();
    for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
    stream(q, 2, 1'b1);
    check_loaded("reload_ignored_done", sum_bytes(q));
  endtask

  task automatic test_reset_midload();
    byte_q_t q1, q2;
    apply_reset();
    for (int i = 0; i < 9; i++) q1.push_back(8'($urandom));
    stream(q1, 2, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset_values("midload_reset");
    for (int i = 0; i < 12; i++) q2.push_back(8'($urandom));
    stream(q2, 2, 1'b0);
    check_loaded("midload_reload_done", sum_bytes(q2));
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_run_ignores_bytes();
    test_reload();
    test_gappy();
    test_reload_ignored();
    test_reset_midload();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ucode_loader.md
Name: ucode_loader

Overview:
Boot-time controller for the microsequencer's writable control store.
- Accepts a byte stream over a valid/ready handshake and assembles full microinstruction words (control | next-address | select bit).
- Writes each word into the control store at sequential addresses.
- Holds the microsequencer in reset (drives its notReset low) until the whole store is loaded, then releases it.
- Supports reloading the store on command.

Parameters:
- ADDR_WIDTH, 13, control-store address width; matches sequencer.
- WORD_WIDTH, 48, microinstruction width (34 control + 13 next + 1 select).
- BYTE_COUNT, 6, bytes per word; must equal ceil(WORD_WIDTH/8).
- WORD_COUNT, 8192, number of words loaded; 1..2^ADDR_WIDTH.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  byte-stream source has a byte.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader accepts a byte this cycle.
- reload  in  1  single-cycle request to reload the store; honoured only in RUN.
- store_write  out  1  write strobe to the control store, one cycle per word.
- store_addr  out  ADDR_WIDTH  control-store write address.
- store_data  out  WORD_WIDTH  assembled microinstruction.
- seq_notReset  out  1  microsequencer reset, active low; high only in RUN.
- done  out  1  store fully loaded; equal to seq_notReset.
- checksum  out  8  mod-256 sum of all bytes accepted since the last load start.

Behaviour:
- States: LOAD, WRITE, RUN. Registers: byte counter (0..BYTE_COUNT-1), word address (ADDR_WIDTH bits), assembly register (WORD_WIDTH bits), checksum (8 bits).
- Reset, taking priority over everything:
  - state <= LOAD; byte counter, word address, assembly register and checksum all <= 0.
  - Outputs after reset: in_ready=1, store_write=0, store_addr=0, store_data=0, seq_notReset=0, done=0, checksum=0.
- in_ready = (state==LOAD), decoded combinationally from state. A byte is accepted when in_valid && in_ready.
- LOAD, on an accepted byte:
  - The byte is stored little-endian: byte k goes to bits [8k+7:8k] of the assembly register.
  - Bits at or above WORD_WIDTH are discarded.
  - checksum <= checksum + in_data (mod 256).
  - If byte counter == BYTE_COUNT-1: counter <= 0 and state <= WRITE. Otherwise counter increments.
- LOAD with in_valid low: no change, no timeout.
- WRITE, one cycle only:
  - store_write=1; store_addr = word address; store_data = assembly register.
  - in_ready=0, so no byte is accepted this cycle.
  - If word address == WORD_COUNT-1, next state is RUN. Otherwise the address increments and the next state is LOAD.
- Timing of a word: last byte accepted in cycle N → store_write high in cycle N+1 → cycle N+2 is LOAD (in_ready=1) or RUN.
- store_write is combinational from state. store_addr and store_data hold their values outside WRITE; consumers qualify them with store_write only.
- Full-load time: at least WORD_COUNT*(BYTE_COUNT+1) cycles.
- RUN:
  - seq_notReset=1, done=1, in_ready=0; bytes offered on the stream are ignored.
  - The first RUN cycle is the first edge at which the sequencer leaves reset. It was held low for at least BYTE_COUNT+1 edges, so it starts from its initial address.
- reload in RUN: next cycle state=LOAD; word address, byte counter, checksum and assembly register <= 0; seq_notReset drops to 0 at the same edge.
- reload in LOAD or WRITE is ignored; a load already in progress is not restarted.
- Reset mid-load discards the partial word. The address restarts at 0 and already-written words are simply overwritten by the new load.
- Word address never wraps: WORD_COUNT ≤ 2^ADDR_WIDTH and the load stops at WORD_COUNT-1. With WORD_COUNT = 2^ADDR_WIDTH, the final write is at the all-ones address.

Test Plan:
- Defaults overridden to WORD_COUNT=2. Reset, then stream bytes 01..0C with in_valid held high → store_write pulses twice:
  - addr 0, data 0x060504030201;
  - addr 1, data 0x0C0B0A090807.
  - done and seq_notReset rise the cycle after the second write.
  - checksum = 0x4E.
- Gappy stream: in_valid toggles every cycle → words identical to the previous test. No byte is accepted during WRITE: in_ready=0 in the cycle after the 6th byte even with in_valid=1.
- Reset asserted after 3 bytes of word 1 → all outputs at reset values. A fresh 12-byte load then writes addr 0 first with the new data and checksum restarts.
- In RUN: pulse reload → next cycle seq_notReset=0, in_ready=1, checksum=0. Reload 12 bytes of 0xFF → data 0xFFFFFFFFFFFF at addrs 0 and 1, checksum 0xF4.
- reload pulsed during LOAD and during WRITE → no effect: addresses continue in sequence and done still rises after the last word. In RUN, bytes offered with in_valid=1 → never accepted, store_write stays 0.
- WORD_WIDTH=47: top byte 0xFF → store_data bit 46 set and no bit 47. Checksum still includes the full 0xFF.
